ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- PS/2 keyboard receive-and-decode stage; sits directly upstream of the two-digit letter-index display path.
- Samples raw PS/2 clock/data pins, assembles 11-bit frames and checks them.
- Strips break (F0) and extended (E0) prefixes and maps letter make codes A–Z to index 1–26.
- Holds the last letter index for display; no PS/2 transmit path.

Parameters:
- TIMEOUT_CYC, 200000, system-clock cycles with no PS/2 falling edge before a partial frame is discarded (2 ms at 100 MHz).
- SYNC_STAGES, 2, synchroniser flop depth on clk_in and data_in (min 2).

Ports:
- clk  in  1  system clock (100 MHz nominal)
- rst  in  1  reset, asynchronous, active-low
- clk_in  in  1  raw PS/2 clock pin, asynchronous to clk
- data_in  in  1  raw PS/2 data pin, asynchronous to clk
- alph  out  5  last letter pressed: 1=A … 26=Z; 0 = none since reset
- key_valid  out  1  one-cycle pulse when alph is (re)loaded by a letter make code
- scan_code  out  8  last accepted data byte of any kind, including prefixes
- frame_err  out  1  one-cycle pulse on parity error, bad stop bit or timeout of a partial frame

Behaviour:
- Reset (rst=0, async): alph=0, key_valid=0, scan_code=8'h00, frame_err=0, FSM=IDLE, bit count=0, brk=0, ext=0, timeout counter=0.
- Both pins pass through SYNC_STAGES flops. A PS/2 falling edge (fe) is detected as sync'd clk_in going 1→0; data is sampled on the same cycle as fe.
- Frame FSM:
  - IDLE: on fe, if data=0 go to RECV with bit count=1. If data=1, treat as a glitch: stay IDLE, no error.
  - RECV: each fe shifts in one bit, LSB first. Bits 1–8 are data, bit 9 is odd parity, bit 10 is stop. On the fe that samples stop, go to CHECK.
  - CHECK (one cycle):
    - Valid frame (XOR of data and parity = 1, stop = 1): pass byte to decoder, return to IDLE.
    - Invalid frame: frame_err=1 for this cycle, byte dropped, brk and ext unchanged, return to IDLE.
- Timeout:
  - Counter clears on every fe and counts otherwise, saturating at TIMEOUT_CYC.
  - In RECV, reaching TIMEOUT_CYC pulses frame_err, discards the partial frame and returns to IDLE.
  - In IDLE the counter has no effect.
  - If fe and timeout occur in the same cycle, fe wins.
- Decoder, on each valid byte B:
  - scan_code<=B.
  - B=F0: brk<=1, nothing else.
  - B=E0: ext<=1, nothing else.
  - Otherwise, if brk=1 or ext=1: no report; brk<=0, ext<=0.
  - Otherwise, if B is a letter make code: alph<=index, key_valid=1.
  - Otherwise (non-letter make code): no change to alph.
- Latency: alph/scan_code update and key_valid pulse on cycle CHECK+1, i.e. 2 clk after the stop-bit fe.
- Typematic repeats of the same make code re-pulse key_valid; alph value is unchanged.
- Letter map (scan code→index):
  - A 1C→1, B 32→2, C 21→3, D 23→4, E 24→5, F 2B→6, G 34→7
  - H 33→8, I 43→9, J 3B→10, K 42→11, L 4B→12, M 3A→13, N 31→14
  - O 44→15, P 4D→16, Q 15→17, R 2D→18, S 1B→19, T 2C→20
  - U 3C→21, V 2A→22, W 1D→23, X 22→24, Y 35→25, Z 1A→26
- Reset asserted mid-frame aborts the frame immediately. After release, reception resumes at the next start bit. A frame cut in half by reset must not produce key_valid.

Decomposition:
- Package ps2_pkg:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, FRAME_BITS=11
  - FSM state encoding IDLE/RECV/CHECK
  - function sc_to_alph(8-bit)→5-bit, returns 0 for non-letters
- Sub-module ps2_frame_rx: synchroniser, edge detect, shift register, parity/stop check, timeout. Outputs byte, byte_vld and frame_err.
- Top level instantiates ps2_frame_rx and adds the brk/ext decoder and output registers.

Test Plan:
- Frame 1C, correct parity, PS/2 clock ~12.5 kHz → alph=1, key_valid exactly one pulse, scan_code=1C.
- Frames 1C, F0, 1C → one key_valid only; alph stays 1; scan_code ends at 1C.
- Frames E0, 1A, then 1A → first 1A ignored; second gives alph=26, key_valid pulse.
- Frame 24 with wrong parity → frame_err pulse; alph unchanged. Then a good 24 → alph=5.
- Send 5 bits, then idle > TIMEOUT_CYC → frame_err pulse, FSM IDLE. A following full frame 1A → alph=26.
- rst low after 6 bits, then release and send full 2D → no key_valid before release, then alph=18. Also: 16-cycle glitch low on clk_in with data_in=1 → no state change.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receive/decode shared definitions.
//   SC_BREAK / SC_EXT : prefix bytes stripped by the decoder
//   FRAME_BITS        : start + 8 data + parity + stop
//   rx_state_e        : frame receiver state encoding
//   sc_to_alph()      : set-2 letter make code -> 1..26, 0 for anything else
package ps2_pkg;

    localparam logic [7:0]  SC_BREAK   = 8'hF0;
    localparam logic [7:0]  SC_EXT     = 8'hE0;
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    function automatic logic [4:0] sc_to_alph(input logic [7:0] sc);
        logic [4:0] idx;
        case (sc)
            8'h1C: idx = 5'd1;   8'h32: idx = 5'd2;   8'h21: idx = 5'd3;
            8'h23: idx = 5'd4;   8'h24: idx = 5'd5;   8'h2B: idx = 5'd6;
            8'h34: idx = 5'd7;   8'h33: idx = 5'd8;   8'h43: idx = 5'd9;
            8'h3B: idx = 5'd10;  8'h42: idx = 5'd11;  8'h4B: idx = 5'd12;
            8'h3A: idx = 5'd13;  8'h31: idx = 5'd14;  8'h44: idx = 5'd15;
            8'h4D: idx = 5'd16;  8'h15: idx = 5'd17;  8'h2D: idx = 5'd18;
            8'h1B: idx = 5'd19;  8'h2C: idx = 5'd20;  8'h3C: idx = 5'd21;
            8'h2A: idx = 5'd22;  8'h1D: idx = 5'd23;  8'h22: idx = 5'd24;
            8'h35: idx = 5'd25;  8'h1A: idx = 5'd26;
            default: idx = 5'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw pins, detects PS/2 clock falling
// edges, shifts in an 11-bit frame LSB first and checks odd parity and stop.
//   clk, rst_n  : system clock, async active-low reset
//   ps2_clk     : raw PS/2 clock pin
//   ps2_data    : raw PS/2 data pin
//   rx_byte     : received data byte (valid while byte_vld is high)
//   byte_vld    : one-cycle strobe, good frame
//   frame_err   : one-cycle strobe, parity/stop error or partial-frame timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    rx_state_e              state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    logic clk_s, data_s, fe, tmo_hit;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign fe      = clk_prev_q & ~clk_s;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC));
    assign rx_byte = shift_q[7:0];

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_s;
        tmo_d       = fe ? '0 : (tmo_hit ? tmo_q : tmo_q + TW'(1));

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_vld  = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            IDLE: begin
                // A falling edge with data high is not a start bit: ignore it.
                if (fe && !data_s) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                // An edge in the same cycle as the timeout keeps the frame alive.
                if (fe) begin
                    shift_d = {data_s, shift_q[9:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_hit) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            CHECK: begin
                // shift_q = {stop, parity, data[7:0]}; odd parity over data+parity.
                state_d = IDLE;
                if (shift_q[9] && (^shift_q[8:0])) begin
                    byte_vld = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receive-and-decode stage. Strips F0 (break) and E0 (extended)
// prefixes and reports letter make codes as index 1..26.
//   clk, rst   : system clock, async active-low reset
//   clk_in     : raw PS/2 clock pin
//   data_in    : raw PS/2 data pin
//   alph       : last letter pressed, 1=A..26=Z, 0 = none since reset
//   key_valid  : one-cycle pulse when alph is loaded by a letter make code
//   scan_code  : last accepted data byte, prefixes included
//   frame_err  : one-cycle pulse on a rejected or timed-out frame
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_in,
    input  logic       data_in,
    output logic [4:0] alph,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_vld;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst),
        .ps2_clk   (clk_in),
        .ps2_data  (data_in),
        .rx_byte   (rx_byte),
        .byte_vld  (byte_vld),
        .frame_err (rx_err)
    );

    logic [4:0] alph_q, alph_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [4:0] idx;

    assign idx = sc_to_alph(rx_byte);

    always_comb begin
        alph_d      = alph_q;
        key_valid_d = 1'b0;
        scan_code_d = scan_code_q;
        brk_d       = brk_q;
        ext_d       = ext_q;

        if (byte_vld) begin
            scan_code_d = rx_byte;
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                // Byte following a prefix is consumed without a report.
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (idx != 5'd0) begin
                alph_d      = idx;
                key_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alph_q      <= '0;
            key_valid_q <= 1'b0;
            scan_code_q <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            alph_q      <= alph_d;
            key_valid_q <= key_valid_d;
            scan_code_q <= scan_code_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
        end
    end

    assign alph      = alph_q;
    assign key_valid = key_valid_q;
    assign scan_code = scan_code_q;
    assign frame_err = rx_err;

endmodule
